mdc_credito_monedas: RTL and testbench

- Coin-credit accumulator directly upstream of the microprogrammed coffee-machine controller (Controlador).
- Synchronises raw coin-acceptor pulses for 5- and 10-unit coins and keeps a running credit.
- Drives the controller's active-low money condition: hm_n goes to Condicion1 and hg_n is available for the large-cup condition.
- Charges credit on controller dispense pulses and pays out change/refunds as serial 5-unit pulses.

---
 rtl/mdc_pkg.sv | 17 +
 rtl/mdc_credito_monedas_if.sv | 27 ++
 rtl/mdc_sync_flanco.sv | 29 ++
 rtl/mdc_credito_monedas.sv | 160 ++++++++++++++++
 tb/tb_mdc_credito_monedas.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mdc_pkg.sv
// rtl/mdc_pkg.sv - shared types and constants for the coin-credit accumulator
package mdc_pkg;

   typedef enum logic [1:0] {
      ESTADO_IDLE     = 2'd0,
      ESTADO_COBRO    = 2'd1,
      ESTADO_DEVOLVER = 2'd2
   } estado_t;

   localparam int VALOR_CINCO     = 5;
   localparam int VALOR_DIEZ      = 10;
   localparam int W_DEF           = 6;
   localparam int PRECIO_PEQ_DEF  = 10;
   localparam int PRECIO_GRA_DEF  = 15;
   localparam int CREDITO_MAX_DEF = 50;

endpackage

// File: rtl/mdc_credito_monedas_if.sv
// rtl/mdc_credito_monedas_if.sv - coin, charge and credit signals between controller side and accumulator
interface mdc_credito_monedas_if #(
   parameter int W = 6
);
   logic         moneda_cinco;
   logic         moneda_diez;
   logic         cobrar_peq;
   logic         cobrar_gra;
   logic         devolver;
   logic [W-1:0] credito;
   logic         hm_n;
   logic         hg_n;
   logic         cambio_cinco;
   logic         rechazo;
   logic         error_cobro;
   logic         ocupado;

   modport master (
      output moneda_cinco, moneda_diez, cobrar_peq, cobrar_gra, devolver,
      input  credito, hm_n, hg_n, cambio_cinco, rechazo, error_cobro, ocupado
   );

   modport slave (
      input  moneda_cinco, moneda_diez, cobrar_peq, cobrar_gra, devolver,
      output credito, hm_n, hg_n, cambio_cinco, rechazo, error_cobro, ocupado
   );
endinterface

// File: rtl/mdc_sync_flanco.sv
// rtl/mdc_sync_flanco.sv - two-flop synchroniser with registered rising-edge pulse
module mdc_sync_flanco (
   input  logic clk,
   input  logic rst,
   input  logic i_dato,
   output logic o_flanco
);
   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic r_flanco;

   // The edge pulse is registered so a coin lands in credit three edges after it rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_s3     <= 1'b0;
         r_flanco <= 1'b0;
      end else begin
         r_s1     <= i_dato;
         r_s2     <= r_s1;
         r_s3     <= r_s2;
         r_flanco <= r_s2 & ~r_s3;
      end
   end

   assign o_flanco = r_flanco;
endmodule

// File: rtl/mdc_credito_monedas.sv
// rtl/mdc_credito_monedas.sv - coin credit accumulator, charge and serial change payout
module mdc_credito_monedas
   import mdc_pkg::*;
#(
   parameter int W           = W_DEF,
   parameter int PRECIO_PEQ  = PRECIO_PEQ_DEF,
   parameter int PRECIO_GRA  = PRECIO_GRA_DEF,
   parameter int CREDITO_MAX = CREDITO_MAX_DEF
) (
   input logic                 clk,
   input logic                 rst,
   mdc_credito_monedas_if.slave bus
);
   localparam logic [W-1:0] L_PEQ   = W'(PRECIO_PEQ);
   localparam logic [W-1:0] L_GRA   = W'(PRECIO_GRA);
   localparam logic [W-1:0] L_CINCO = W'(VALOR_CINCO);
   localparam logic [W:0]   L_MAX   = (W+1)'(CREDITO_MAX);

   estado_t      r_estado;
   logic [W-1:0] r_credito;
   logic         r_fase;
   logic         r_hm_n;
   logic         r_hg_n;
   logic         r_cambio;
   logic         r_rechazo;
   logic         r_error;
   logic         r_ocupado;

   logic         w_ev_cinco;
   logic         w_ev_diez;
   logic         w_ev_any;
   logic [W:0]   w_suma_cinco;
   logic [W:0]   w_suma_diez;
   estado_t      w_sig_estado;
   logic [W-1:0] w_sig_credito;
   logic         w_sig_fase;
   logic         w_sig_cambio;
   logic         w_sig_rechazo;
   logic         w_sig_error;

   mdc_sync_flanco u_sync_cinco (
      .clk      (clk),
      .rst      (rst),
      .i_dato   (bus.moneda_cinco),
      .o_flanco (w_ev_cinco)
   );

   mdc_sync_flanco u_sync_diez (
      .clk      (clk),
      .rst      (rst),
      .i_dato   (bus.moneda_diez),
      .o_flanco (w_ev_diez)
   );

   assign w_ev_any     = w_ev_cinco | w_ev_diez;
   assign w_suma_cinco = {1'b0, r_credito} + (W+1)'(VALOR_CINCO);
   assign w_suma_diez  = {1'b0, r_credito} + (W+1)'(VALOR_DIEZ);

   always_comb begin
      w_sig_estado  = r_estado;
      w_sig_credito = r_credito;
      w_sig_fase    = r_fase;
      w_sig_cambio  = 1'b0;
      w_sig_rechazo = 1'b0;
      w_sig_error   = 1'b0;
      case (r_estado)
         ESTADO_IDLE: begin
            if (bus.cobrar_gra) begin
               w_sig_rechazo = w_ev_any;
               if (r_credito >= L_GRA) begin
                  w_sig_credito = r_credito - L_GRA;
                  w_sig_estado  = ESTADO_COBRO;
               end else begin
                  w_sig_error = 1'b1;
               end
            end else if (bus.cobrar_peq) begin
               w_sig_rechazo = w_ev_any;
               if (r_credito >= L_PEQ) begin
                  w_sig_credito = r_credito - L_PEQ;
                  w_sig_estado  = ESTADO_COBRO;
               end else begin
                  w_sig_error = 1'b1;
               end
            end else if (bus.devolver && (r_credito != '0)) begin
               w_sig_rechazo = w_ev_any;
               w_sig_estado  = ESTADO_DEVOLVER;
               w_sig_fase    = 1'b0;
            end else if (w_ev_diez) begin
               // A simultaneous 5-unit coin always bounces; the 10-unit one wins.
               w_sig_rechazo = w_ev_cinco;
               if (w_suma_diez <= L_MAX) begin
                  w_sig_credito = w_suma_diez[W-1:0];
               end else begin
                  w_sig_rechazo = 1'b1;
               end
            end else if (w_ev_cinco) begin
               if (w_suma_cinco <= L_MAX) begin
                  w_sig_credito = w_suma_cinco[W-1:0];
               end else begin
                  w_sig_rechazo = 1'b1;
               end
            end
         end
         ESTADO_COBRO: begin
            w_sig_rechazo = w_ev_any;
            w_sig_fase    = 1'b0;
            w_sig_estado  = (r_credito != '0) ? ESTADO_DEVOLVER : ESTADO_IDLE;
         end
         ESTADO_DEVOLVER: begin
            w_sig_rechazo = w_ev_any;
            if (!r_fase) begin
               w_sig_cambio  = 1'b1;
               w_sig_credito = r_credito - L_CINCO;
               w_sig_fase    = 1'b1;
            end else begin
               w_sig_fase = 1'b0;
               if (r_credito == '0) begin
                  w_sig_estado = ESTADO_IDLE;
               end
            end
         end
         default: begin
            w_sig_estado = ESTADO_IDLE;
         end
      endcase
   end

   // Flags are registered from next-state values so they track credito in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado  <= ESTADO_IDLE;
         r_credito <= '0;
         r_fase    <= 1'b0;
         r_hm_n    <= 1'b1;
         r_hg_n    <= 1'b1;
         r_cambio  <= 1'b0;
         r_rechazo <= 1'b0;
         r_error   <= 1'b0;
         r_ocupado <= 1'b0;
      end else begin
         r_estado  <= w_sig_estado;
         r_credito <= w_sig_credito;
         r_fase    <= w_sig_fase;
         r_hm_n    <= !((w_sig_estado == ESTADO_IDLE) && (w_sig_credito >= L_PEQ));
         r_hg_n    <= !((w_sig_estado == ESTADO_IDLE) && (w_sig_credito >= L_GRA));
         r_cambio  <= w_sig_cambio;
         r_rechazo <= w_sig_rechazo;
         r_error   <= w_sig_error;
         r_ocupado <= (w_sig_estado != ESTADO_IDLE);
      end
   end

   assign bus.credito      = r_credito;
   assign bus.hm_n         = r_hm_n;
   assign bus.hg_n         = r_hg_n;
   assign bus.cambio_cinco = r_cambio;
   assign bus.rechazo      = r_rechazo;
   assign bus.error_cobro  = r_error;
   assign bus.ocupado      = r_ocupado;
endmodule

// File: tb/tb_mdc_credito_monedas.sv
// tb/tb_mdc_credito_monedas.sv - directed bench for the coin-credit accumulator
module tb_mdc_credito_monedas;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   fallos = 0;
   int   n_cambio;
   int   n_rech;
   int   pos0;
   int   pos1;

   mdc_credito_monedas_if #(.W(6)) bus ();

   mdc_credito_monedas dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fallos++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic hacer_reset();
      bus.moneda_cinco = 1'b0;
      bus.moneda_diez  = 1'b0;
      bus.cobrar_peq   = 1'b0;
      bus.cobrar_gra   = 1'b0;
      bus.devolver     = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Raises the coin lines before edge N and leaves the bench at the negedge after N+3.
   task automatic cargar(input bit diez, input bit cinco);
      @(negedge clk);
      bus.moneda_diez  = diez;
      bus.moneda_cinco = cinco;
      @(negedge clk);
      @(negedge clk);
      bus.moneda_diez  = 1'b0;
      bus.moneda_cinco = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pedir(input bit gra, input bit peq, input bit dev);
      bus.cobrar_gra = gra;
      bus.cobrar_peq = peq;
      bus.devolver   = dev;
      @(negedge clk);
      bus.cobrar_gra = 1'b0;
      bus.cobrar_peq = 1'b0;
      bus.devolver   = 1'b0;
   endtask

   initial begin
      hacer_reset();
      chk("rst_credito", bus.credito, 0);
      chk("rst_hm_n", bus.hm_n, 1);
      chk("rst_hg_n", bus.hg_n, 1);
      chk("rst_ocupado", bus.ocupado, 0);
      chk("rst_cambio", bus.cambio_cinco, 0);

      // 5 then 10: latency check one edge early and on the update edge
      @(negedge clk);
      bus.moneda_cinco = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.moneda_cinco = 1'b0;
      @(negedge clk);
      chk("lat_cinco_early", bus.credito, 0);
      @(negedge clk);
      chk("lat_cinco", bus.credito, 5);
      chk("hm_n_at5", bus.hm_n, 1);
      @(negedge clk);
      bus.moneda_diez = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.moneda_diez = 1'b0;
      @(negedge clk);
      chk("lat_diez_early", bus.credito, 5);
      chk("hm_n_early", bus.hm_n, 1);
      @(negedge clk);
      chk("credito_15", bus.credito, 15);
      chk("hm_n_15", bus.hm_n, 0);
      chk("hg_n_15", bus.hg_n, 0);

      // insufficient large charge, then a small charge that empties credit
      hacer_reset();
      cargar(1, 0);
      chk("credito_10", bus.credito, 10);
      chk("hg_n_10", bus.hg_n, 1);
      pedir(1, 0, 0);
      chk("error_gra", bus.error_cobro, 1);
      chk("credito_tras_error", bus.credito, 10);
      chk("ocupado_error", bus.ocupado, 0);
      pedir(0, 1, 0);
      chk("error_cleared", bus.error_cobro, 0);
      chk("credito_peq", bus.credito, 0);
      chk("ocupado_cobro", bus.ocupado, 1);
      chk("hm_n_cobro", bus.hm_n, 1);
      n_cambio = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.cambio_cinco) n_cambio++;
      end
      chk("peq_sin_cambio", n_cambio, 0);
      chk("peq_idle", bus.ocupado, 0);

      // 25 credit, large coffee, 10 returned as two 5-unit pulses
      hacer_reset();
      cargar(1, 0);
      cargar(1, 0);
      cargar(0, 1);
      chk("credito_25", bus.credito, 25);
      pedir(1, 0, 0);
      chk("credito_gra", bus.credito, 10);
      n_cambio = 0;
      pos0 = -1;
      pos1 = -1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bus.cambio_cinco) begin
            if (n_cambio == 0) pos0 = k;
            else pos1 = k;
            n_cambio++;
         end
      end
      chk("gra_n_cambio", n_cambio, 2);
      chk("gra_pos0", pos0, 2);
      chk("gra_pos1", pos1, 4);
      chk("gra_credito_fin", bus.credito, 0);
      chk("gra_hm_n_fin", bus.hm_n, 1);
      chk("gra_ocupado_fin", bus.ocupado, 0);

      // overflow rejection at 45, cap at 50, simultaneous coins
      hacer_reset();
      for (int k = 0; k < 4; k++) cargar(1, 0);
      cargar(0, 1);
      chk("credito_45", bus.credito, 45);
      cargar(1, 0);
      chk("rechazo_overflow", bus.rechazo, 1);
      chk("credito_45_keep", bus.credito, 45);
      cargar(0, 1);
      chk("credito_50", bus.credito, 50);
      chk("rechazo_50", bus.rechazo, 0);
      hacer_reset();
      cargar(1, 1);
      chk("simul_credito", bus.credito, 10);
      chk("simul_rechazo", bus.rechazo, 1);

      // refund 20 with a coin arriving mid-payout
      hacer_reset();
      cargar(1, 0);
      cargar(1, 0);
      pedir(0, 0, 1);
      chk("dev_ocupado", bus.ocupado, 1);
      bus.moneda_cinco = 1'b1;
      n_cambio = 0;
      n_rech = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 2) bus.moneda_cinco = 1'b0;
         if (bus.cambio_cinco) n_cambio++;
         if (bus.rechazo) n_rech++;
      end
      chk("dev_n_cambio", n_cambio, 4);
      chk("dev_n_rechazo", n_rech, 1);
      chk("dev_credito_fin", bus.credito, 0);
      chk("dev_ocupado_fin", bus.ocupado, 0);

      // async reset in the middle of a payout at credit 15
      hacer_reset();
      cargar(1, 0);
      cargar(1, 0);
      pedir(0, 0, 1);
      @(negedge clk);
      chk("mid_cambio", bus.cambio_cinco, 1);
      chk("mid_credito", bus.credito, 15);
      rst = 1'b1;
      #1;
      chk("async_credito", bus.credito, 0);
      chk("async_ocupado", bus.ocupado, 0);
      chk("async_cambio", bus.cambio_cinco, 0);
      chk("async_hm_n", bus.hm_n, 1);
      @(negedge clk);
      rst = 1'b0;
      n_cambio = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.cambio_cinco) n_cambio++;
      end
      chk("post_rst_cambio", n_cambio, 0);

      // refund request with empty credit does nothing
      pedir(0, 0, 1);
      chk("dev_vacio_ocupado", bus.ocupado, 0);
      @(negedge clk);
      chk("dev_vacio_cambio", bus.cambio_cinco, 0);

      $display("%0d/%0d checks passed", total - fallos, total);
      $finish;
   end
endmodule
